// File: rtl/dram_global_controller_if.sv
// Channel bundle of the DRAM frontend scheduler: core requests, backend commands,
// returned read data and tagged read responses.
interface dram_global_controller_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4,
  parameter int CORE_W = 2
);
  logic                           o_scheduler_ready;
  logic                           i_interconnection_request_valid;
  logic [CORE_W+ID_W+ADDR_W:0]    i_interconnection_request;
  logic [DATA_W-1:0]              i_interconnection_write_data;
  logic                           i_interconnection_write_data_last;
  logic                           i_backend_controller_ready;
  logic                           o_frontend_command_valid;
  logic [ADDR_W:0]                o_frontend_command;
  logic [DATA_W-1:0]              o_frontend_write_data;
  logic                           o_stall_backend_controller;
  logic                           o_frontend_receive_ready;
  logic                           i_returned_data_valid;
  logic [DATA_W-1:0]              i_returned_data;
  logic                           i_interconnection_ready;
  logic                           o_scheduler_request_valid;
  logic [DATA_W-1:0]              o_scheduler_read_data;
  logic                           o_scheduler_read_data_last;
  logic [ID_W-1:0]                o_scheduler_request_id;
  logic [CORE_W-1:0]              o_scheduler_core_num;

  modport slave (
    output o_scheduler_ready,
    input  i_interconnection_request_valid, i_interconnection_request,
    input  i_interconnection_write_data, i_interconnection_write_data_last,
    input  i_backend_controller_ready,
    output o_frontend_command_valid, o_frontend_command, o_frontend_write_data,
    output o_stall_backend_controller, o_frontend_receive_ready,
    input  i_returned_data_valid, i_returned_data, i_interconnection_ready,
    output o_scheduler_request_valid, o_scheduler_read_data, o_scheduler_read_data_last,
    output o_scheduler_request_id, o_scheduler_core_num
  );

  modport master (
    input  o_scheduler_ready,
    output i_interconnection_request_valid, i_interconnection_request,
    output i_interconnection_write_data, i_interconnection_write_data_last,
    output i_backend_controller_ready,
    input  o_frontend_command_valid, o_frontend_command, o_frontend_write_data,
    input  o_stall_backend_controller, o_frontend_receive_ready,
    output i_returned_data_valid, i_returned_data, i_interconnection_ready,
    input  o_scheduler_request_valid, o_scheduler_read_data, o_scheduler_read_data_last,
    input  o_scheduler_request_id, o_scheduler_core_num
  );
endinterface

// File: rtl/dram_global_controller.sv
// In-order DRAM frontend scheduler: request FIFO -> backend commands, outstanding-read
// tag FIFO, and a response FIFO that returns read data tagged with core and ID.
module dram_global_controller_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  // Pointers carry one extra wrap bit so full and empty differ only in the MSB.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full)
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst && push && !full)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end
endmodule

module dram_global_controller #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int CORE_W    = 2,
  parameter int CMD_DEPTH = 4,
  parameter int TAG_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  dram_global_controller_if.slave bus
);
  localparam int TAG_W = CORE_W + ID_W;
  localparam int REQ_W = TAG_W + 1 + ADDR_W;
  localparam int CMD_W = REQ_W + DATA_W;
  localparam int RSP_W = TAG_W + DATA_W;

  logic             in_reset_reg;
  logic             sched_ready;
  logic             cmd_push, cmd_pop, cmd_full, cmd_empty, cmd_valid;
  logic [CMD_W-1:0] cmd_push_data, cmd_head;
  logic             head_is_write;
  logic             tag_push, tag_pop, tag_full, tag_empty;
  logic [TAG_W-1:0] tag_head;
  logic             recv_ready;
  logic             rsp_push, rsp_pop, rsp_full, rsp_empty;
  logic [RSP_W-1:0] rsp_head;

  // Holds acceptance off while reset is asserted; clears the cycle after release.
  always_ff @(posedge i_clk)
    in_reset_reg <= i_rst_n;

  assign sched_ready   = !cmd_full && !in_reset_reg;
  assign cmd_push      = bus.i_interconnection_request_valid && sched_ready;
  assign cmd_push_data = {bus.i_interconnection_request,
                          bus.i_interconnection_request[ADDR_W] ?
                            bus.i_interconnection_write_data : {DATA_W{1'b0}}};

  dram_global_controller_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(i_clk), .srst(i_rst_n), .push(cmd_push), .push_data(cmd_push_data),
    .pop(cmd_pop), .head(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );

  // A read at the head waits until there is room to remember who asked for it.
  assign head_is_write = cmd_head[DATA_W+ADDR_W];
  assign cmd_valid     = !cmd_empty && !(!head_is_write && tag_full);
  assign cmd_pop       = cmd_valid && bus.i_backend_controller_ready;
  assign tag_push      = cmd_pop && !head_is_write;

  dram_global_controller_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(i_clk), .srst(i_rst_n), .push(tag_push), .push_data(cmd_head[CMD_W-1 -: TAG_W]),
    .pop(tag_pop), .head(tag_head), .full(tag_full), .empty(tag_empty)
  );

  assign recv_ready = !tag_empty && !rsp_full;
  assign tag_pop    = bus.i_returned_data_valid && recv_ready;
  assign rsp_push   = tag_pop;
  assign rsp_pop    = !rsp_empty && bus.i_interconnection_ready;

  dram_global_controller_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(i_clk), .srst(i_rst_n), .push(rsp_push), .push_data({tag_head, bus.i_returned_data}),
    .pop(rsp_pop), .head(rsp_head), .full(rsp_full), .empty(rsp_empty)
  );

  assign bus.o_scheduler_ready          = sched_ready;
  assign bus.o_frontend_command_valid   = cmd_valid;
  assign bus.o_frontend_command         = cmd_empty ? '0 : cmd_head[DATA_W +: ADDR_W+1];
  assign bus.o_frontend_write_data      = cmd_empty ? '0 : cmd_head[DATA_W-1:0];
  assign bus.o_stall_backend_controller = rsp_full;
  assign bus.o_frontend_receive_ready   = recv_ready;

  assign bus.o_scheduler_request_valid  = !rsp_empty;
  assign bus.o_scheduler_read_data_last = !rsp_empty;
  assign bus.o_scheduler_read_data      = rsp_empty ? '0 : rsp_head[DATA_W-1:0];
  assign bus.o_scheduler_request_id     = rsp_empty ? '0 : rsp_head[DATA_W +: ID_W];
  assign bus.o_scheduler_core_num       = rsp_empty ? '0 : rsp_head[RSP_W-1 -: CORE_W];
endmodule

// File: tb/tb_dram_global_controller.sv
// Bench for dram_global_controller: directed vector table, corner-case sequences,
// and randomized traffic against a queue-based reference model.
module tb_dram_global_controller;
  localparam int ADDR_W = 32, DATA_W = 128, ID_W = 4, CORE_W = 2;

  typedef struct {
    logic rst; logic rv; logic [1:0] core; logic [3:0] id; logic we; logic [31:0] addr;
    logic [127:0] wd; logic be; logic retv; logic [127:0] retd; logic ic;
  } in_t;
  typedef struct {
    logic rdy; logic cv; logic [32:0] cmd; logic [127:0] wd; logic stall; logic recv;
    logic rv; logic [127:0] rd; logic [3:0] id; logic [1:0] core;
  } out_t;
  typedef struct { in_t i; out_t o; } vec_t;
  typedef struct { logic [1:0] core; logic [3:0] id; logic we; logic [31:0] addr; logic [127:0] d; } cmd_t;
  typedef struct { logic [1:0] core; logic [3:0] id; logic [127:0] d; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  cmd_t cq[$];
  rsp_t tq[$];
  rsp_t rq[$];
  bit   m_rst = 1'b1;

  always #5 clk = ~clk;

  dram_global_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CORE_W(CORE_W)) bus ();

  dram_global_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CORE_W(CORE_W),
                           .CMD_DEPTH(4), .TAG_DEPTH(4), .RSP_DEPTH(2)) dut (
    .i_clk(clk), .i_rst_n(rst), .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic in_t mk_in(input logic r, input logic v, input logic [1:0] c, input logic [3:0] id,
                                input logic we, input logic [31:0] a, input logic [127:0] wd,
                                input logic be, input logic retv, input logic [127:0] retd, input logic ic);
    in_t x;
    x.rst = r; x.rv = v; x.core = c; x.id = id; x.we = we; x.addr = a; x.wd = wd;
    x.be = be; x.retv = retv; x.retd = retd; x.ic = ic;
    return x;
  endfunction

  function automatic out_t mk_out(input logic rdy, input logic cv, input logic [32:0] cmd, input logic [127:0] wd,
                                  input logic stall, input logic recv, input logic rv, input logic [127:0] rd,
                                  input logic [3:0] id, input logic [1:0] core);
    out_t o;
    o.rdy = rdy; o.cv = cv; o.cmd = cmd; o.wd = wd; o.stall = stall; o.recv = recv;
    o.rv = rv; o.rd = rd; o.id = id; o.core = core;
    return o;
  endfunction

  task automatic apply(input in_t x);
    rst = x.rst;
    bus.i_interconnection_request_valid   = x.rv;
    bus.i_interconnection_request         = {x.core, x.id, x.we, x.addr};
    bus.i_interconnection_write_data      = x.wd;
    bus.i_interconnection_write_data_last = 1'b1;
    bus.i_backend_controller_ready        = x.be;
    bus.i_returned_data_valid             = x.retv;
    bus.i_returned_data                   = x.retd;
    bus.i_interconnection_ready           = x.ic;
  endtask

  task automatic check_out(input string p, input out_t e);
    chk({p, ".ready"},  {127'd0, bus.o_scheduler_ready}, {127'd0, e.rdy});
    chk({p, ".cmd_v"},  {127'd0, bus.o_frontend_command_valid}, {127'd0, e.cv});
    chk({p, ".cmd"},    {95'd0, bus.o_frontend_command}, {95'd0, e.cmd});
    chk({p, ".wdata"},  bus.o_frontend_write_data, e.wd);
    chk({p, ".stall"},  {127'd0, bus.o_stall_backend_controller}, {127'd0, e.stall});
    chk({p, ".recv"},   {127'd0, bus.o_frontend_receive_ready}, {127'd0, e.recv});
    chk({p, ".rsp_v"},  {127'd0, bus.o_scheduler_request_valid}, {127'd0, e.rv});
    chk({p, ".last"},   {127'd0, bus.o_scheduler_read_data_last}, {127'd0, e.rv});
    chk({p, ".rdata"},  bus.o_scheduler_read_data, e.rd);
    chk({p, ".id"},     {124'd0, bus.o_scheduler_request_id}, {124'd0, e.id});
    chk({p, ".core"},   {126'd0, bus.o_scheduler_core_num}, {126'd0, e.core});
  endtask

  // Reference model: observable state is just the contents of three queues.
  function automatic out_t model_out();
    out_t o;
    o = mk_out(1'b0, 1'b0, 33'd0, 128'd0, 1'b0, 1'b0, 1'b0, 128'd0, 4'd0, 2'd0);
    o.rdy = !m_rst && (cq.size() < 4);
    if (cq.size() > 0) begin
      o.cv  = cq[0].we || (tq.size() < 4);
      o.cmd = {cq[0].we, cq[0].addr};
      o.wd  = cq[0].we ? cq[0].d : 128'd0;
    end
    o.stall = (rq.size() == 2);
    o.recv  = (tq.size() > 0) && (rq.size() < 2);
    if (rq.size() > 0) begin
      o.rv = 1'b1; o.rd = rq[0].d; o.id = rq[0].id; o.core = rq[0].core;
    end
    return o;
  endfunction

  task automatic model_step(input in_t x);
    out_t o;
    cmd_t c;
    rsp_t t;
    if (x.rst) begin
      cq.delete(); tq.delete(); rq.delete();
      m_rst = 1'b1;
    end else begin
      o = model_out();
      if (o.rv && x.ic) t = rq.pop_front();
      if (x.retv && o.recv) begin
        t = tq.pop_front(); t.d = x.retd; rq.push_back(t);
      end
      if (o.cv && x.be) begin
        c = cq.pop_front();
        if (!c.we) begin
          t.core = c.core; t.id = c.id; t.d = 128'd0; tq.push_back(t);
        end
      end
      if (x.rv && o.rdy) begin
        c.core = x.core; c.id = x.id; c.we = x.we; c.addr = x.addr; c.d = x.wd;
        cq.push_back(c);
      end
      m_rst = 1'b0;
    end
  endtask

  vec_t         tbl[13];
  in_t          idle_be, idle_st, rnd;
  out_t         zero_o;
  logic [127:0] a5, d0, d1;
  logic [32:0]  ecmd;
  int           ic_pct, rv_pct;

  initial begin
    a5 = {16{8'hA5}};
    d0 = {4{32'hD0D0_0001}};
    d1 = {4{32'hD1D1_0002}};
    zero_o  = mk_out(0, 0, 33'd0, 128'd0, 0, 0, 0, 128'd0, 4'd0, 2'd0);
    idle_be = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 0, 128'd0, 1);

    for (int k = 0; k < 3; k++) begin
      tbl[k].i = mk_in(1, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 0, 0, 128'd0, 0);
      tbl[k].o = zero_o;
    end
    tbl[3].i  = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 0, 0, 128'd0, 1);
    tbl[3].o  = mk_out(1, 0, 33'd0, 128'd0, 0, 0, 0, 128'd0, 4'd0, 2'd0);
    tbl[4].i  = mk_in(0, 1, 2'd2, 4'd5, 1, 32'h100, a5, 1, 0, 128'd0, 1);
    tbl[4].o  = mk_out(1, 1, {1'b1, 32'h100}, a5, 0, 0, 0, 128'd0, 4'd0, 2'd0);
    tbl[5].i  = idle_be;
    tbl[5].o  = tbl[3].o;
    tbl[6].i  = mk_in(0, 1, 2'd1, 4'd3, 0, 32'h40, a5, 0, 0, 128'd0, 1);
    tbl[6].o  = mk_out(1, 1, {1'b0, 32'h40}, 128'd0, 0, 0, 0, 128'd0, 4'd0, 2'd0);
    tbl[7].i  = idle_be;
    tbl[7].o  = mk_out(1, 0, 33'd0, 128'd0, 0, 1, 0, 128'd0, 4'd0, 2'd0);
    tbl[8].i  = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, 128'h1234, 0);
    tbl[8].o  = mk_out(1, 0, 33'd0, 128'd0, 0, 0, 1, 128'h1234, 4'd3, 2'd1);
    tbl[9].i  = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 0, 128'd0, 0);
    tbl[9].o  = tbl[8].o;
    tbl[10].i = idle_be;
    tbl[10].o = tbl[3].o;
    tbl[11].i = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, 128'hDEAD, 1);
    tbl[11].o = tbl[3].o;
    tbl[12].i = idle_be;
    tbl[12].o = tbl[3].o;

    apply(tbl[0].i);
    @(negedge clk);
    for (int k = 0; k < 13; k++) begin
      apply(tbl[k].i);
      tick();
      check_out($sformatf("vec%0d", k), tbl[k].o);
    end

    // Backpressure: five writes against a stalled backend, then in-order drain.
    apply(mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 0, 0, 128'd0, 1));
    for (int k = 0; k < 5; k++) begin
      apply(mk_in(0, 1, 2'(k), 4'(k), 1, 32'h1000 + 32'(k * 16), 128'(k + 1), 0, 0, 128'd0, 1));
      tick();
      chk($sformatf("bp.ready%0d", k), {127'd0, bus.o_scheduler_ready}, (k < 3) ? 128'd1 : 128'd0);
    end
    apply(idle_be);
    for (int k = 0; k < 4; k++) begin
      ecmd = {1'b1, 32'h1000 + 32'(k * 16)};
      chk($sformatf("bp.cmd_v%0d", k), {127'd0, bus.o_frontend_command_valid}, 128'd1);
      chk($sformatf("bp.cmd%0d", k), {95'd0, bus.o_frontend_command}, {95'd0, ecmd});
      chk($sformatf("bp.wdata%0d", k), bus.o_frontend_write_data, 128'(k + 1));
      tick();
    end
    chk("bp.cmd_v_end", {127'd0, bus.o_frontend_command_valid}, 128'd0);
    chk("bp.ready_end", {127'd0, bus.o_scheduler_ready}, 128'd1);

    // Tag full: four reads in flight block the fifth until one returns.
    for (int k = 0; k < 5; k++) begin
      apply(mk_in(0, 1, 2'(k), 4'(k), 0, 32'h200 + 32'(k * 4), 128'd0, 1, 0, 128'd0, 1));
      tick();
    end
    apply(idle_be);
    chk("tag.cmd_v_blk", {127'd0, bus.o_frontend_command_valid}, 128'd0);
    chk("tag.recv", {127'd0, bus.o_frontend_receive_ready}, 128'd1);
    tick();
    chk("tag.cmd_v_hold", {127'd0, bus.o_frontend_command_valid}, 128'd0);
    apply(mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, 128'hBEEF, 1));
    tick();
    apply(idle_be);
    chk("tag.rsp_v", {127'd0, bus.o_scheduler_request_valid}, 128'd1);
    chk("tag.rsp_data", bus.o_scheduler_read_data, 128'hBEEF);
    chk("tag.rsp_id", {124'd0, bus.o_scheduler_request_id}, 128'd0);
    chk("tag.cmd_v_free", {127'd0, bus.o_frontend_command_valid}, 128'd1);
    ecmd = {1'b0, 32'h210};
    chk("tag.cmd5", {95'd0, bus.o_frontend_command}, {95'd0, ecmd});
    tick();
    chk("tag.cmd_v_done", {127'd0, bus.o_frontend_command_valid}, 128'd0);
    chk("tag.rsp_v_done", {127'd0, bus.o_scheduler_request_valid}, 128'd0);

    // Reset with four reads outstanding discards them.
    apply(mk_in(1, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 0, 128'd0, 1));
    tick();
    check_out("midrst", zero_o);
    apply(idle_be);
    tick();
    check_out("postrst", tbl[3].o);

    // Response stall: three reads, two returned with the interconnection stalled.
    for (int k = 0; k < 3; k++) begin
      apply(mk_in(0, 1, 2'(3 - k), 4'(10 + k), 0, 32'h300 + 32'(k * 4), 128'd0, 1, 0, 128'd0, 0));
      tick();
    end
    idle_st = mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 0, 128'd0, 0);
    apply(idle_st);
    tick();
    apply(mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, d0, 0));
    tick();
    apply(mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, d1, 0));
    tick();
    apply(mk_in(0, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 1, 1, 128'hDEAD, 0));
    for (int k = 0; k < 2; k++) begin
      tick();
      check_out($sformatf("stall%0d", k), mk_out(1, 0, 33'd0, 128'd0, 1, 0, 1, d0, 4'd10, 2'd3));
    end
    apply(idle_be);
    tick();
    check_out("drain0", mk_out(1, 0, 33'd0, 128'd0, 0, 1, 1, d1, 4'd11, 2'd2));
    tick();
    check_out("drain1", mk_out(1, 0, 33'd0, 128'd0, 0, 1, 0, 128'd0, 4'd0, 2'd0));

    // Randomized traffic against the reference model, with shifting pressure.
    rnd = mk_in(1, 0, 2'd0, 4'd0, 0, 32'd0, 128'd0, 0, 0, 128'd0, 0);
    apply(rnd);
    model_step(rnd);
    tick();
    check_out("rnd_rst", model_out());
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 500) % 3)
        0:       begin ic_pct = 80; rv_pct = 60; end
        1:       begin ic_pct = 25; rv_pct = 90; end
        default: begin ic_pct = 95; rv_pct = 20; end
      endcase
      rnd.rst  = ($urandom_range(0, 299) == 0);
      rnd.rv   = ($urandom_range(0, 99) < 70);
      rnd.core = 2'($urandom);
      rnd.id   = 4'($urandom);
      rnd.we   = 1'($urandom);
      rnd.addr = $urandom;
      rnd.wd   = {$urandom, $urandom, $urandom, $urandom};
      rnd.be   = ($urandom_range(0, 99) < 70);
      rnd.retv = ($urandom_range(0, 99) < rv_pct);
      rnd.retd = {$urandom, $urandom, $urandom, $urandom};
      rnd.ic   = ($urandom_range(0, 99) < ic_pct);
      apply(rnd);
      model_step(rnd);
      tick();
      check_out($sformatf("rnd%0d", cyc), model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dram_global_controller.md
# dram_global_controller

In-order frontend scheduler between the multi-core interconnection and the DRAM backend controller. It accepts core requests (read/write) with a single write-data beat and queues them as DRAM commands for the backend. It tracks outstanding reads by core number and request ID, and returns read data to the interconnection tagged with the originating core and ID.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 128, data beat width (read and write)
- ID_W, 4, request ID width
- CORE_W, 2, core number width
- CMD_DEPTH, 4, command FIFO entries (power of 2)
- TAG_DEPTH, 4, outstanding-read tag FIFO entries (power of 2)
- RSP_DEPTH, 2, response FIFO entries (power of 2)

- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  synchronous, active-high reset; the port keeps the codebase name despite its suffix
- o_scheduler_ready  out  1  request FIFO can accept
- i_interconnection_request_valid  in  1  request present
- i_interconnection_request  in  CORE_W+ID_W+1+ADDR_W  {core_num, request_id, is_write, addr}, MSB first
- i_interconnection_write_data  in  DATA_W  write beat, sampled with a write request
- i_interconnection_write_data_last  in  1  must be 1 with every write request
- i_backend_controller_ready  in  1  backend accepts command
- o_frontend_command_valid  out  1  command at head is issuable
- o_frontend_command  out  1+ADDR_W  {is_write, addr}
- o_frontend_write_data  out  DATA_W  write beat of head command; 0 for reads
- o_stall_backend_controller  out  1  response FIFO full
- o_frontend_receive_ready  out  1  can accept returned read data
- i_returned_data_valid  in  1  backend read beat present
- i_returned_data  in  DATA_W  read beat
- i_interconnection_ready  in  1  interconnection accepts response
- o_scheduler_request_valid  out  1  response at head
- o_scheduler_read_data  out  DATA_W  read beat
- o_scheduler_read_data_last  out  1  equals o_scheduler_request_valid; responses are one beat
- o_scheduler_request_id  out  ID_W  ID of the returned read
- o_scheduler_core_num  out  CORE_W  core of the returned read

## Operation
- Command FIFO stores {core_num, request_id, is_write, addr, write_data}; write_data is stored as 0 for reads.
- Accept when valid && o_scheduler_ready; o_scheduler_ready = !cmd_full.
- A write accepted with write_data_last=0 is still enqueued. Bench must not drive it.
- Issue is strictly in order, with no reordering and no bank scheduling.
- o_frontend_command_valid = !cmd_empty && !(head.is_write==0 && tag_full).
- Command, write data, and the head's core/ID are taken from the FIFO head.
- Pop on command_valid && i_backend_controller_ready.
- A popped read pushes {core_num, request_id} into the tag FIFO in the same cycle. Writes push nothing and produce no response.
- o_frontend_receive_ready = !tag_empty && !rsp_full.
- On i_returned_data_valid && receive_ready: pop the tag and push {core, id, data} into the response FIFO.
- Returned data arriving while receive_ready=0 is dropped.
- o_stall_backend_controller = rsp_full.
- Response outputs are driven from the response FIFO head. Pop on o_scheduler_request_valid && i_interconnection_ready.
- The head holds stable while the interconnection is not ready.
- Full/ready flags use pre-pop state: a full FIFO never accepts a push in the same cycle as a pop.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
- Pointers are log2(depth)+1 bits and wrap modulo 2·depth; full and empty are derived from the MSB compare.

## Timing
- Reset (i_rst_n=1 at an edge) empties all FIFOs.
- During and after reset all outputs are 0, except o_scheduler_ready=1 from the first cycle after reset.
- Reset mid-transfer discards all queued commands, tags, and responses.
- Request to o_frontend_command_valid: 1 cycle when the FIFO was empty.
- Back-to-back issue: 1 command per cycle while the backend is ready.
- Returned data to o_scheduler_request_valid: 1 cycle.
- Sustained throughput: 1 request, 1 command, and 1 response per cycle.
- Every output is a function of registered state only; there is no combinational input-to-output path.

## Test plan
- Reset check: hold i_rst_n=1 for 3 cycles. Expect all outputs 0, then o_scheduler_ready=1 and command_valid=0.
- Single write: core 2, id 5, addr 0x100, data 0xA5..A5, backend ready.
  - Command {1,0x100} with that data appears the next cycle.
  - No response is ever produced.
- Single read: core 1, id 3, addr 0x40. After issue, return data 0x1234.
  - Next cycle: request_valid=1, last=1, id=3, core=1, data=0x1234.
- Backpressure: backend ready=0 with 5 requests. Expect 4 accepted, then o_scheduler_ready=0.
  - With ready=1 they issue in order, one per cycle.
- Tag full: issue 4 reads with no return data. A 5th queued read holds command_valid=0.
  - After one return, the 5th read issues.
- Response stall: i_interconnection_ready=0 with 2 reads returned. Expect o_stall_backend_controller=1 and receive_ready=0.
  - Response outputs stay stable until ready, then drain in order.
